fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//   Instruction-fetch stage that sits directly upstream of the instruction memory.
//   Owns the program counter and drives the 3-bit fetch address into the memory.
//   Captures the returned 16-bit word into an IF/ID pipeline register for the decoder.
//   Supports start/halt control, decoder stall, and branch/jump redirect with flush.
// PARAMETERS
//   PC_W     3   program counter width; memory depth = 2**PC_W words
//   INSTR_W  16  instruction width (op3 rs3 rt3 rd3 func4 / op3 rs3 rt3 imm7)
//   RESET_PC 0   PC value loaded on reset
// PORTS
//   clk          in   1        single clock, all state updates on rising edge
//   rst          in   1        asynchronous reset, active-high
//   start        in   1        IDLE->RUN request
//   halt         in   1        RUN->IDLE request
//   stall        in   1        decoder back-pressure: hold PC and IF/ID
//   redirect     in   1        branch/jump taken: load redirect_pc, flush IF/ID
//   redirect_pc  in   PC_W     target address
//   pc           out  PC_W     fetch address to instruction memory (= PC register)
//   instruction  in   INSTR_W  combinational read data from instruction memory
//   ifid_instr   out  INSTR_W  registered instruction
//   ifid_pc      out  PC_W     address ifid_instr was fetched from
//   ifid_valid   out  1        ifid_instr is a real instruction, not a bubble
//   busy         out  1        1 while state == RUN
// BEHAVIOUR
//   Reset (async, any time, including mid-fetch):
//     pc=RESET_PC; ifid_instr=0; ifid_pc=0; ifid_valid=0; state=IDLE; busy=0.
//   FSM: IDLE, RUN (1-bit encoding, IDLE=0).
//     IDLE: start=1 && halt=0 -> RUN. If start and halt are both 1 -> stay IDLE.
//     RUN:  halt=1 -> IDLE.
//   Priority each edge: redirect > halt > stall > normal advance.
//   RUN, normal (no redirect/halt/stall):
//     ifid_instr<=instruction; ifid_pc<=pc; ifid_valid<=1; pc<=pc+1 mod 2**PC_W.
//   Latency: word at address N appears on ifid_* one edge after pc==N.
//   Wrap-around: pc=2**PC_W-1 advances to 0. No overflow flag.
//   stall=1 (RUN, no redirect/halt): pc and all ifid_* hold. No fetch is lost or repeated.
//   redirect=1 (either state): pc<=redirect_pc; ifid_valid<=0; ifid_instr<=0.
//     State is unchanged. redirect in IDLE presets the start address.
//     redirect overrides a simultaneous stall: the flush always happens.
//   halt=1 in RUN without redirect:
//     ifid_valid<=0; pc holds (resume continues at the same address).
//   IDLE without redirect: pc holds, ifid_valid<=0, ifid_instr/ifid_pc hold.
//   First RUN cycle after start: ifid_valid is still 0 (one fill bubble).
//     The first valid instruction appears on the following edge.
//   busy is a registered decode of state.
// STRUCTURE
//   Shared package (fetch_pkg):
//     PC_W, INSTR_W, field slices OP=[15:13], RS=[12:10], RT=[9:7], RD=[6:4],
//     FUNC=[3:0], IMM=[6:0], state encodings.
//   One sub-module: if_id_reg.
//     Holds ifid_instr, ifid_pc, ifid_valid.
//     Inputs: load, flush, clear_valid; async reset.
//     fetch_unit keeps the PC register and FSM.
// TESTING (bench uses the instruction memory with its standard program)
//   1 Reset then start at t0 -> pc steps 0,1,2. ifid_valid=0 at t1.
//     At t2: ifid_instr=16'h0500, ifid_pc=0. Next edge: 16'h0501, ifid_pc=1.
//   2 Run to pc=7 -> next edge pc=0. ifid_pc=7 with valid=1, then ifid_instr=16'h0500.
//   3 stall=1 for 3 cycles with pc=3 -> pc stays 3 and ifid holds 16'h0502/pc=2.
//     After release: ifid_instr=16'h0503.
//   4 stall=1 and redirect=1, redirect_pc=5 -> next edge pc=5, ifid_valid=0.
//     Then ifid_instr=16'hEF9F, ifid_pc=5.
//   5 halt at pc=4 -> IDLE, busy=0, ifid_valid=0, pc stays 4.
//     start and halt together in IDLE -> stays IDLE.
//     start alone -> resumes fetching from 4 (16'h2540).
//   6 Assert rst mid-RUN between edges -> outputs go to reset values immediately.
//     State is IDLE, and pc stays 0 until start.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch slice: default widths, reset
// address, instruction field positions and the fetch FSM state encoding.
package fetch_pkg;

  localparam int PC_W     = 3;
  localparam int INSTR_W  = 16;
  localparam int RESET_PC = 0;

  // Instruction field positions (R-type: op rs rt rd func, I-type: op rs rt imm)
  localparam int OP_HI   = 15;
  localparam int OP_LO   = 13;
  localparam int RS_HI   = 12;
  localparam int RS_LO   = 10;
  localparam int RT_HI   = 9;
  localparam int RT_LO   = 7;
  localparam int RD_HI   = 6;
  localparam int RD_LO   = 4;
  localparam int FUNC_HI = 3;
  localparam int FUNC_LO = 0;
  localparam int IMM_HI  = 6;
  localparam int IMM_LO  = 0;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } fetch_state_e;

  // Opcode field of a fetched word, for consumers that need early decode
  function automatic logic [OP_HI-OP_LO:0] instr_op(input logic [INSTR_W-1:0] instr);
    return instr[OP_HI:OP_LO];
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: captures the fetched word and its address.
// flush zeroes the word and drops valid, clear_valid only drops valid,
// load captures a new word; flush wins over clear_valid wins over load.
module if_id_reg #(
  parameter int PC_W    = fetch_pkg::PC_W,
  parameter int INSTR_W = fetch_pkg::INSTR_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               flush,
  input  logic               clear_valid,
  input  logic [INSTR_W-1:0] instr_in,
  input  logic [PC_W-1:0]    pc_in,
  output logic [INSTR_W-1:0] ifid_instr,
  output logic [PC_W-1:0]    ifid_pc,
  output logic               ifid_valid
);
  import fetch_pkg::*;

  logic [INSTR_W-1:0] instr_p1;
  logic [PC_W-1:0]    pc_p1;
  logic               vld_p1;

  // IF -> ID stage boundary
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_p1 <= '0;
      pc_p1    <= '0;
      vld_p1   <= 1'b0;
    end else if (flush) begin
      instr_p1 <= '0;
      vld_p1   <= 1'b0;
    end else if (clear_valid) begin
      vld_p1   <= 1'b0;
    end else if (load) begin
      instr_p1 <= instr_in;
      pc_p1    <= pc_in;
      vld_p1   <= 1'b1;
    end
  end

  assign ifid_instr = instr_p1;
  assign ifid_pc    = pc_p1;
  assign ifid_valid = vld_p1;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC and the IDLE/RUN control FSM, drives
// the fetch address to instruction memory and feeds the IF/ID register.
// Per-edge priority: redirect > halt > stall > normal advance.
module fetch_unit #(
  parameter int PC_W     = fetch_pkg::PC_W,
  parameter int INSTR_W  = fetch_pkg::INSTR_W,
  parameter int RESET_PC = fetch_pkg::RESET_PC
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               halt,
  input  logic               stall,
  input  logic               redirect,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic [PC_W-1:0]    pc,
  input  logic [INSTR_W-1:0] instruction,
  output logic [INSTR_W-1:0] ifid_instr,
  output logic [PC_W-1:0]    ifid_pc,
  output logic               ifid_valid,
  output logic               busy
);
  import fetch_pkg::*;

  fetch_state_e    state_q, state_d;
  logic            busy_q;
  logic [PC_W-1:0] pc_p0, pc_d;
  logic            run;
  logic            advance;
  logic            clear_valid;

  assign run         = (state_q == ST_RUN);
  // A real fetch happens only in RUN with nothing of higher priority pending.
  // The edge that leaves IDLE is itself an IDLE edge, which is what produces
  // the single fill bubble after start.
  assign advance     = run && !redirect && !halt && !stall;
  assign clear_valid = !run || halt;

  // Next-state: redirect leaves the state untouched; start+halt together stays IDLE
  always_comb begin
    state_d = state_q;
    if (!redirect) begin
      case (state_q)
        ST_IDLE: if (start && !halt) state_d = ST_RUN;
        ST_RUN:  if (halt)           state_d = ST_IDLE;
        default:                     state_d = ST_IDLE;
      endcase
    end
  end

  // Next PC: redirect target, sequential advance with natural wrap, or hold
  always_comb begin
    pc_d = pc_p0;
    if (redirect)     pc_d = redirect_pc;
    else if (advance) pc_d = pc_p0 + PC_W'(1);
  end

  // Fetch stage state: FSM, registered busy decode and program counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      pc_p0   <= PC_W'(RESET_PC);
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d == ST_RUN);
      pc_p0   <= pc_d;
    end
  end

  if_id_reg #(
    .PC_W    (PC_W),
    .INSTR_W (INSTR_W)
  ) u_if_id_reg (
    .clk         (clk),
    .rst         (rst),
    .load        (advance),
    .flush       (redirect),
    .clear_valid (clear_valid),
    .instr_in    (instruction),
    .pc_in       (pc_p0),
    .ifid_instr  (ifid_instr),
    .ifid_pc     (ifid_pc),
    .ifid_valid  (ifid_valid)
  );

  assign pc   = pc_p0;
  assign busy = busy_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a driver applies directed and random
// control patterns and pushes the expected post-edge outputs from a
// behavioural model; a monitor pops and compares after every rising edge.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        halt = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [2:0]  redirect_pc = 3'd0;
  logic [2:0]  pc;
  logic [15:0] instruction;
  logic [15:0] ifid_instr;
  logic [2:0]  ifid_pc;
  logic        ifid_valid;
  logic        busy;

  always #5 clk = ~clk;

  // Standard program held in the instruction memory
  logic [15:0] mem [0:7] = '{16'h0500, 16'h0501, 16'h0502, 16'h0503,
                             16'h2540, 16'hEF9F, 16'h1F07, 16'hC0DE};
  assign instruction = mem[pc];

  fetch_unit dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .halt        (halt),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .pc          (pc),
    .instruction (instruction),
    .ifid_instr  (ifid_instr),
    .ifid_pc     (ifid_pc),
    .ifid_valid  (ifid_valid),
    .busy        (busy)
  );

  typedef struct {
    int          pc;
    bit          iv;
    logic [15:0] ii;
    int          ip;
    bit          busy;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Behavioural model of the fetch stage
  bit          m_run;
  int          m_pc;
  bit          m_iv;
  logic [15:0] m_ii;
  int          m_ip;

  task automatic chk(input string name, input int act, input int req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_run = 1'b0; m_pc = 0; m_iv = 1'b0; m_ii = 16'h0; m_ip = 0;
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_pc"},    int'(pc), 0);
    chk({tag, "_valid"}, int'(ifid_valid), 0);
    chk({tag, "_instr"}, int'(ifid_instr), 0);
    chk({tag, "_ifpc"},  int'(ifid_pc), 0);
    chk({tag, "_busy"},  int'(busy), 0);
  endtask

  // One clock of stimulus; the model's next outputs go to the scoreboard
  task automatic step(input bit s, input bit h, input bit st, input bit r, input int rpc);
    exp_t e;
    @(negedge clk);
    start = s; halt = h; stall = st; redirect = r; redirect_pc = 3'(rpc);
    if (r) begin
      m_pc = rpc % 8; m_iv = 1'b0; m_ii = 16'h0;
    end else if (m_run) begin
      if (h) begin
        m_run = 1'b0; m_iv = 1'b0;
      end else if (!st) begin
        m_ii = mem[m_pc]; m_ip = m_pc; m_iv = 1'b1; m_pc = (m_pc + 1) % 8;
      end
    end else begin
      m_iv = 1'b0;
      if (s && !h) m_run = 1'b1;
    end
    e.pc = m_pc; e.iv = m_iv; e.ii = m_ii; e.ip = m_ip; e.busy = m_run;
    exp_q.push_back(e);
  endtask

  task automatic run_until(input int target);
    for (int i = 0; i < 16 && m_pc != target; i++) step(0, 0, 0, 0, 0);
  endtask

  // Monitor: compare DUT outputs against the oldest expectation after each edge
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (!rst && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("pc",         int'(pc),         e.pc);
      chk("ifid_valid", int'(ifid_valid), int'(e.iv));
      chk("ifid_instr", int'(ifid_instr), int'(e.ii));
      if (e.iv) chk("ifid_pc", int'(ifid_pc), e.ip);
      chk("busy",       int'(busy),       int'(e.busy));
    end
  end

  initial begin
    model_reset();
    #1 rst = 1'b1;
    #2 chk_reset_values("reset");
    @(negedge clk);
    rst = 1'b0;

    // Start and sequential fetch, including the fill bubble
    step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 0);   // wraps 7 -> 0

    // Stall hold at pc=3, then release
    run_until(3);
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);

    // Redirect wins over stall
    step(0, 0, 1, 1, 5);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);

    // Halt at pc=4, start+halt in IDLE, resume
    run_until(4);
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);

    // Redirect in IDLE presets the start address; redirect+halt in RUN keeps RUN
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 6);
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 1, 0, 1, 2);
    step(0, 0, 0, 0, 0);

    // Randomized control mix
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 5) == 0, $urandom_range(0, 11) == 0,
           $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
           int'($urandom_range(0, 7)));
    end

    // Asynchronous reset mid-RUN
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 chk_reset_values("async_reset");
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);

    // Bounded drain of the scoreboard
    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    chk("drain", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
